// File: rtl/reg_bus_arbiter.sv
// -----------------------------------------------------------------------------
// reg_bus_arbiter
//
// Purpose:
//   Shares one register-file port between two masters.
//     - Port A: SPI host register interface (one-cycle request pulse). It
//       cannot stall, so a request that arrives while the port is busy is
//       parked in a one-deep pending slot and issued with bounded latency.
//     - Port B: internal sequencer (req/ack level handshake). It is protected
//       from starvation by a counter that forces a B grant after STARVE_LIMIT
//       consecutive A grants while B is waiting.
//   Every transaction walks IDLE -> ISSUE -> RESP -> IDLE. The target sees
//   exactly one t_en cycle (ISSUE). Read data is sampled at the end of RESP.
//   Completion (a_rvalid / b_ack) shows up in the following IDLE cycle, and
//   that same IDLE cycle may already grant the next request.
//
// Ports:
//   clk, rst_n               clock (rising edge), asynchronous active-low reset
//   a_addr/a_write/a_wdata   port A request fields, valid with a_new_req
//   a_new_req                port A request pulse
//   a_rdata/a_rvalid         port A read data and its one-cycle update strobe
//   a_overrun/a_overrun_clr  sticky "pending A request overwritten" flag, clear
//   b_req                    port B request level (fields stable while high)
//   b_addr/b_write/b_wdata   port B request fields
//   b_ack/b_rdata            port B completion pulse and read data
//   t_en/t_addr/t_write/
//   t_wdata/t_rdata          register-file target port
// -----------------------------------------------------------------------------
module reg_bus_arbiter #(
    parameter int ADDR_W       = 6,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    // port A
    input  logic [ADDR_W-1:0] a_addr,
    input  logic              a_write,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              a_new_req,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_rvalid,
    output logic              a_overrun,
    input  logic              a_overrun_clr,
    // port B
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic              b_write,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    // target
    output logic              t_en,
    output logic [ADDR_W-1:0] t_addr,
    output logic              t_write,
    output logic [DATA_W-1:0] t_wdata,
    input  logic [DATA_W-1:0] t_rdata
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t              state_reg;

    // one-deep parking slot for port A
    logic                a_pend_reg;
    logic [ADDR_W-1:0]   a_pend_addr_reg;
    logic                a_pend_write_reg;
    logic [DATA_W-1:0]   a_pend_wdata_reg;

    logic [CNT_W-1:0]    starve_cnt_reg;

    // grant registers: the transaction currently owning the target port
    logic                grant_is_a_reg;
    logic                grant_write_reg;
    logic [ADDR_W-1:0]   grant_addr_reg;
    logic [DATA_W-1:0]   grant_wdata_reg;

    logic                t_en_reg;
    logic [DATA_W-1:0]   a_rdata_reg;
    logic                a_rvalid_reg;
    logic                a_overrun_reg;
    logic                b_ack_reg;
    logic [DATA_W-1:0]   b_rdata_reg;

    // arbitration decision for the current cycle
    logic                is_idle;
    logic                a_cand;
    logic                b_cand;
    logic                starved;
    logic                grant_a;
    logic                grant_b;
    logic                capture_a;
    logic                set_overrun;
    logic [ADDR_W-1:0]   sel_addr;
    logic                sel_write;
    logic [DATA_W-1:0]   sel_wdata;

    assign is_idle = (state_reg == ST_IDLE);
    assign a_cand  = a_pend_reg | a_new_req;
    // A B request still high in its own ack cycle is the previous one; it is
    // only treated as a fresh request from the next cycle on.
    assign b_cand  = b_req & ~b_ack_reg;
    assign starved = (starve_cnt_reg == STARVE_MAX);

    assign grant_b = is_idle & b_cand & (~a_cand | starved);
    assign grant_a = is_idle & a_cand & ~grant_b;

    // Any A pulse that is not turned straight into a grant gets parked. When
    // A is granted in IDLE, the fresh pulse is the one issued and the slot is
    // emptied, so the only overwrite that counts as an overrun is one where
    // the slot stays occupied.
    assign capture_a   = a_new_req & ~grant_a;
    assign set_overrun = capture_a & a_pend_reg;

    always_comb begin
        sel_addr  = b_addr;
        sel_write = b_write;
        sel_wdata = b_wdata;
        if (grant_a) begin
            if (a_new_req) begin
                sel_addr  = a_addr;
                sel_write = a_write;
                sel_wdata = a_wdata;
            end else begin
                sel_addr  = a_pend_addr_reg;
                sel_write = a_pend_write_reg;
                sel_wdata = a_pend_wdata_reg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= ST_IDLE;
            a_pend_reg       <= 1'b0;
            a_pend_addr_reg  <= '0;
            a_pend_write_reg <= 1'b0;
            a_pend_wdata_reg <= '0;
            starve_cnt_reg   <= '0;
            grant_is_a_reg   <= 1'b0;
            grant_write_reg  <= 1'b0;
            grant_addr_reg   <= '0;
            grant_wdata_reg  <= '0;
            t_en_reg         <= 1'b0;
            a_rdata_reg      <= '0;
            a_rvalid_reg     <= 1'b0;
            a_overrun_reg    <= 1'b0;
            b_ack_reg        <= 1'b0;
            b_rdata_reg      <= '0;
        end else begin
            // single-cycle strobes
            t_en_reg     <= 1'b0;
            a_rvalid_reg <= 1'b0;
            b_ack_reg    <= 1'b0;

            // pending slot for port A
            if (grant_a) begin
                a_pend_reg <= 1'b0;
            end
            if (capture_a) begin
                a_pend_reg       <= 1'b1;
                a_pend_addr_reg  <= a_addr;
                a_pend_write_reg <= a_write;
                a_pend_wdata_reg <= a_wdata;
            end

            // a fresh overrun beats a simultaneous clear
            if (set_overrun) begin
                a_overrun_reg <= 1'b1;
            end else if (a_overrun_clr) begin
                a_overrun_reg <= 1'b0;
            end

            // starvation counter only moves on arbitration (IDLE) cycles
            if (is_idle) begin
                if (grant_b || !b_req) begin
                    starve_cnt_reg <= '0;
                end else if (grant_a && !starved) begin
                    starve_cnt_reg <= starve_cnt_reg + CNT_W'(1);
                end
            end

            case (state_reg)
                ST_IDLE: begin
                    if (grant_a || grant_b) begin
                        grant_is_a_reg  <= grant_a;
                        grant_addr_reg  <= sel_addr;
                        grant_write_reg <= sel_write;
                        grant_wdata_reg <= sel_wdata;
                        t_en_reg        <= 1'b1;
                        state_reg       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state_reg <= ST_RESP;
                end
                ST_RESP: begin
                    // target read data is valid in this cycle; hand it to the
                    // owner and signal completion in the next (IDLE) cycle
                    state_reg <= ST_IDLE;
                    if (grant_is_a_reg) begin
                        if (!grant_write_reg) begin
                            a_rvalid_reg <= 1'b1;
                            a_rdata_reg  <= t_rdata;
                        end
                    end else begin
                        b_ack_reg <= 1'b1;
                        if (!grant_write_reg) begin
                            b_rdata_reg <= t_rdata;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign t_en      = t_en_reg;
    assign t_addr    = grant_addr_reg;
    assign t_write   = grant_write_reg;
    assign t_wdata   = grant_wdata_reg;
    assign a_rdata   = a_rdata_reg;
    assign a_rvalid  = a_rvalid_reg;
    assign a_overrun = a_overrun_reg;
    assign b_ack     = b_ack_reg;
    assign b_rdata   = b_rdata_reg;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg_bus_arbiter
//
// Self-checking bench for reg_bus_arbiter. Directed scenario tasks check
// fixed cycle-exact expectations; test_random drives random traffic on both
// ports and compares every cycle with a transaction-level reference model
// that tracks grants by cycle number. The target register file is a small
// memory inside the bench that answers t_rdata the cycle after t_en.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_reg_bus_arbiter;

    localparam int LIMIT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] a_addr = '0;
    logic       a_write = 1'b0;
    logic [7:0] a_wdata = '0;
    logic       a_new_req = 1'b0;
    logic [7:0] a_rdata;
    logic       a_rvalid;
    logic       a_overrun;
    logic       a_overrun_clr = 1'b0;
    logic       b_req = 1'b0;
    logic [5:0] b_addr = '0;
    logic       b_write = 1'b0;
    logic [7:0] b_wdata = '0;
    logic       b_ack;
    logic [7:0] b_rdata;
    logic       t_en;
    logic [5:0] t_addr;
    logic       t_write;
    logic [7:0] t_wdata;
    logic [7:0] t_rdata;

    logic       pre_we = 1'b0;
    logic [5:0] pre_addr = '0;
    logic [7:0] pre_data = '0;
    logic [7:0] mem [64];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    reg_bus_arbiter #(
        .ADDR_W(6),
        .DATA_W(8),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .a_addr(a_addr),
        .a_write(a_write),
        .a_wdata(a_wdata),
        .a_new_req(a_new_req),
        .a_rdata(a_rdata),
        .a_rvalid(a_rvalid),
        .a_overrun(a_overrun),
        .a_overrun_clr(a_overrun_clr),
        .b_req(b_req),
        .b_addr(b_addr),
        .b_write(b_write),
        .b_wdata(b_wdata),
        .b_ack(b_ack),
        .b_rdata(b_rdata),
        .t_en(t_en),
        .t_addr(t_addr),
        .t_write(t_write),
        .t_wdata(t_wdata),
        .t_rdata(t_rdata)
    );

    // Target register file: read data only meaningful the cycle after t_en,
    // junk otherwise so a mistimed sample shows up as wrong data.
    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end
        if (t_en) begin
            t_rdata <= mem[t_addr];
            if (t_write) mem[t_addr] <= t_wdata;
        end else begin
            t_rdata <= 8'($urandom);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [5:0] addr, input logic [7:0] data);
        pre_we   = 1'b1;
        pre_addr = addr;
        pre_data = data;
        tick();
        pre_we   = 1'b0;
    endtask

    task automatic test_reset();
        logic [34:0] outs;
        rst_n = 1'b0;
        for (int i = 0; i < 64; i++) begin
            preload(6'(i), 8'($urandom));
        end
        outs = {t_en, t_addr, t_write, t_wdata, a_rdata, a_rvalid, a_overrun, b_ack, b_rdata};
        checks++;
        if (outs !== 35'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0", outs);
        end
        rst_n = 1'b1;
        tick();
        tick();
        outs = {t_en, t_addr, t_write, t_wdata, a_rdata, a_rvalid, a_overrun, b_ack, b_rdata};
        checks++;
        if (outs !== 35'd0) begin
            errors++;
            $display("FAIL reset_idle_outputs got=%h exp=0", outs);
        end
        $display("reset: outputs idle after release");
    endtask

    task automatic test_a_read();
        preload(6'h05, 8'hA5);
        a_new_req = 1'b1; a_addr = 6'h05; a_write = 1'b0; a_wdata = 8'h00;
        tick();                                   // N+1
        a_new_req = 1'b0;
        checks++;
        if ({t_en, t_addr, t_write} !== {1'b1, 6'h05, 1'b0}) begin
            errors++;
            $display("FAIL a_read_issue got=%b/%h/%b exp=1/05/0", t_en, t_addr, t_write);
        end
        tick();                                   // N+2
        checks++;
        if ({t_en, a_rvalid} !== 2'b00) begin
            errors++;
            $display("FAIL a_read_resp got=t_en %b rvalid %b exp=0/0", t_en, a_rvalid);
        end
        tick();                                   // N+3
        checks++;
        if ({a_rvalid, a_rdata} !== {1'b1, 8'hA5}) begin
            errors++;
            $display("FAIL a_read_data got=%b/%h exp=1/a5", a_rvalid, a_rdata);
        end
        tick();                                   // N+4
        checks++;
        if (a_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL a_read_pulse got=%b exp=0", a_rvalid);
        end
        $display("a_read: addr=05 data=%h", a_rdata);
    endtask

    task automatic test_a_write();
        int n_ten = 0;
        int n_rv = 0;
        a_new_req = 1'b1; a_addr = 6'h10; a_write = 1'b1; a_wdata = 8'h3C;
        tick();
        a_new_req = 1'b0;
        checks++;
        if ({t_en, t_addr, t_write, t_wdata} !== {1'b1, 6'h10, 1'b1, 8'h3C}) begin
            errors++;
            $display("FAIL a_write_issue got=%b/%h/%b/%h exp=1/10/1/3c", t_en, t_addr, t_write, t_wdata);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (t_en) n_ten++;
            if (a_rvalid) n_rv++;
        end
        checks++;
        if (n_ten !== 0 || n_rv !== 0) begin
            errors++;
            $display("FAIL a_write_strobes got=t_en %0d rvalid %0d exp=0/0", n_ten, n_rv);
        end
        checks++;
        if (a_rdata !== 8'hA5) begin
            errors++;
            $display("FAIL a_write_rdata_hold got=%h exp=a5", a_rdata);
        end
        checks++;
        if (mem[6'h10] !== 8'h3C) begin
            errors++;
            $display("FAIL a_write_target got=%h exp=3c", mem[6'h10]);
        end
        $display("a_write: addr=10 data=3c");
    endtask

    task automatic test_a_b_same();
        int n_ack = 0;
        preload(6'h20, 8'h5A);
        preload(6'h07, 8'h77);
        a_new_req = 1'b1; a_addr = 6'h07; a_write = 1'b0;
        b_req = 1'b1; b_addr = 6'h20; b_write = 1'b0; b_wdata = 8'h00;
        tick();                                   // N+1
        a_new_req = 1'b0;
        checks++;
        if ({t_en, t_addr} !== {1'b1, 6'h07}) begin
            errors++;
            $display("FAIL ab_a_first got=%b/%h exp=1/07", t_en, t_addr);
        end
        tick(); tick();                           // N+3
        checks++;
        if ({a_rvalid, a_rdata} !== {1'b1, 8'h77}) begin
            errors++;
            $display("FAIL ab_a_data got=%b/%h exp=1/77", a_rvalid, a_rdata);
        end
        tick();                                   // N+4
        checks++;
        if ({t_en, t_addr, t_write} !== {1'b1, 6'h20, 1'b0}) begin
            errors++;
            $display("FAIL ab_b_issue got=%b/%h/%b exp=1/20/0", t_en, t_addr, t_write);
        end
        tick(); tick();                           // N+6
        checks++;
        if ({b_ack, b_rdata} !== {1'b1, 8'h5A}) begin
            errors++;
            $display("FAIL ab_b_ack got=%b/%h exp=1/5a", b_ack, b_rdata);
        end
        b_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (b_ack) n_ack++;
        end
        checks++;
        if (n_ack !== 0) begin
            errors++;
            $display("FAIL ab_b_ack_once got=%0d extra acks exp=0", n_ack);
        end
        $display("a_b_same: A addr=07 data=77, B addr=20 data=%h", b_rdata);
    endtask

    task automatic test_starve();
        logic [5:0] seen[$];
        logic [5:0] exp_seq [6];
        int n_ack = 0;
        exp_seq = '{6'h30, 6'h31, 6'h32, 6'h33, 6'h21, 6'h34};
        preload(6'h21, 8'h5B);
        b_req = 1'b1; b_addr = 6'h21; b_write = 1'b0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            a_new_req = (cyc % 3 == 0) && (cyc <= 12);
            a_addr    = 6'(6'h30 + cyc / 3);
            a_write   = 1'b0;
            tick();
            a_new_req = 1'b0;
            if (t_en) begin
                seen.push_back(t_addr);
                $display("starve: t_en addr=%h", t_addr);
            end
            if (b_ack) begin
                n_ack++;
                b_req = 1'b0;
            end
        end
        checks++;
        if (seen.size() !== 6) begin
            errors++;
            $display("FAIL starve_count got=%0d exp=6", seen.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (seen[i] !== exp_seq[i]) begin
                    errors++;
                    $display("FAIL starve_order[%0d] got=%h exp=%h", i, seen[i], exp_seq[i]);
                end
            end
        end
        checks++;
        if (n_ack !== 1 || b_rdata !== 8'h5B) begin
            errors++;
            $display("FAIL starve_b_ack got=%0d/%h exp=1/5b", n_ack, b_rdata);
        end
        checks++;
        if (a_overrun !== 1'b0) begin
            errors++;
            $display("FAIL starve_no_overrun got=%b exp=0", a_overrun);
        end
    endtask

    task automatic test_overrun();
        preload(6'h22, 8'h6C);
        b_req = 1'b1; b_addr = 6'h22; b_write = 1'b0;
        tick();                                   // B in ISSUE
        a_new_req = 1'b1; a_addr = 6'h01; a_write = 1'b0;
        tick();                                   // B in RESP
        a_addr = 6'h02;
        tick();                                   // IDLE, ack
        a_new_req = 1'b0;
        checks++;
        if ({a_overrun, b_ack} !== 2'b11) begin
            errors++;
            $display("FAIL overrun_set got=ovr %b ack %b exp=1/1", a_overrun, b_ack);
        end
        b_req = 1'b0;
        tick();
        checks++;
        if ({t_en, t_addr} !== {1'b1, 6'h02}) begin
            errors++;
            $display("FAIL overrun_latest got=%b/%h exp=1/02", t_en, t_addr);
        end
        tick(); tick();
        a_overrun_clr = 1'b1;
        tick();
        a_overrun_clr = 1'b0;
        checks++;
        if (a_overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clr got=%b exp=0", a_overrun);
        end
        // a clear coinciding with a fresh overwrite must lose
        b_req = 1'b1;
        tick();
        a_new_req = 1'b1; a_addr = 6'h03;
        tick();
        a_addr = 6'h04; a_overrun_clr = 1'b1;
        tick();
        a_new_req = 1'b0; a_overrun_clr = 1'b0; b_req = 1'b0;
        checks++;
        if (a_overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set_wins got=%b exp=1", a_overrun);
        end
        tick(); tick(); tick(); tick();
        a_overrun_clr = 1'b1;
        tick();
        a_overrun_clr = 1'b0;
        $display("overrun: latest pending issued, flag=%b after clear", a_overrun);
    endtask

    task automatic test_async_reset();
        int n_evt = 0;
        preload(6'h23, 8'h11);
        b_req = 1'b1; b_addr = 6'h23; b_write = 1'b0;
        tick();
        a_new_req = 1'b1; a_addr = 6'h05; a_write = 1'b0;
        tick();
        a_new_req = 1'b0;
        tick();
        b_req = 1'b0;
        tick();                                   // pending A read in ISSUE
        checks++;
        if ({t_en, t_addr} !== {1'b1, 6'h05}) begin
            errors++;
            $display("FAIL arst_pre_issue got=%b/%h exp=1/05", t_en, t_addr);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({t_en, a_rvalid, b_ack} !== 3'b000) begin
            errors++;
            $display("FAIL arst_immediate got=%b%b%b exp=000", t_en, a_rvalid, b_ack);
        end
        tick(); tick();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (t_en || a_rvalid || b_ack) n_evt++;
        end
        checks++;
        if (n_evt !== 0 || a_rdata !== 8'h00) begin
            errors++;
            $display("FAIL arst_quiet got=%0d events rdata %h exp=0/00", n_evt, a_rdata);
        end
        $display("async_reset: in-flight read dropped");
        test_a_read();
    endtask

    task automatic test_random();
        logic [7:0] m_mem [64];
        int         idle_at, cur_grant, cnt;
        bit         cur_valid, cur_a, cur_w, pend, pend_w, ovr;
        logic [5:0] cur_addr, pend_addr, s_addr;
        logic [7:0] cur_wdata, cur_rd, pend_wdata, s_wdata, m_ardata, m_brdata;
        bit         exp_ten, exp_rv, exp_ack, idle, acand, bcand, ga, gb, cap, s_w;

        rst_n = 1'b0; a_new_req = 1'b0; b_req = 1'b0; a_overrun_clr = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 64; i++) m_mem[i] = mem[i];
        idle_at = 0; cur_grant = -10; cnt = 0;
        cur_valid = 0; cur_a = 0; cur_w = 0; pend = 0; pend_w = 0; ovr = 0;
        cur_addr = '0; cur_wdata = '0; cur_rd = '0; pend_addr = '0; pend_wdata = '0;
        m_ardata = '0; m_brdata = '0;

        for (int c = 0; c < 600; c++) begin
            exp_ten = cur_valid && (c == cur_grant + 1);
            exp_rv  = cur_valid && (c == cur_grant + 3) && cur_a && !cur_w;
            exp_ack = cur_valid && (c == cur_grant + 3) && !cur_a;
            if (exp_rv)  m_ardata = cur_rd;
            if (exp_ack && !cur_w) m_brdata = cur_rd;

            checks++;
            if ({t_en, t_addr, t_write, t_wdata} !== {exp_ten, cur_addr, cur_w, cur_wdata}) begin
                errors++;
                $display("FAIL rand_target c=%0d got=%b/%h/%b/%h exp=%b/%h/%b/%h",
                         c, t_en, t_addr, t_write, t_wdata, exp_ten, cur_addr, cur_w, cur_wdata);
            end
            checks++;
            if ({a_rvalid, a_rdata, a_overrun} !== {exp_rv, m_ardata, ovr}) begin
                errors++;
                $display("FAIL rand_port_a c=%0d got=%b/%h/%b exp=%b/%h/%b",
                         c, a_rvalid, a_rdata, a_overrun, exp_rv, m_ardata, ovr);
            end
            checks++;
            if ({b_ack, b_rdata} !== {exp_ack, m_brdata}) begin
                errors++;
                $display("FAIL rand_port_b c=%0d got=%b/%h exp=%b/%h", c, b_ack, b_rdata, exp_ack, m_brdata);
            end
            if (exp_ten)
                $display("rand c=%0d %s %s addr=%h wdata=%h", c, cur_a ? "A" : "B",
                         cur_w ? "wr" : "rd", cur_addr, cur_wdata);

            // stimulus for this cycle
            a_new_req     = ($urandom_range(0, 3) == 0);
            a_addr        = 6'($urandom);
            a_write       = 1'($urandom);
            a_wdata       = 8'($urandom);
            a_overrun_clr = ($urandom_range(0, 7) == 0);
            if (!b_req) begin
                if ($urandom_range(0, 3) == 0) begin
                    b_req   = 1'b1;
                    b_addr  = 6'($urandom);
                    b_write = 1'($urandom);
                    b_wdata = 8'($urandom);
                end
            end else if (exp_ack && ($urandom_range(0, 1) == 0)) begin
                b_req = 1'b0;
            end

            // reference model: decision made at the coming clock edge
            idle  = (c >= idle_at);
            acand = pend || a_new_req;
            bcand = b_req && !exp_ack;
            gb    = idle && bcand && (!acand || cnt == LIMIT);
            ga    = idle && acand && !gb;
            s_addr = b_addr; s_w = b_write; s_wdata = b_wdata;
            if (ga) begin
                if (a_new_req) begin
                    s_addr = a_addr; s_w = a_write; s_wdata = a_wdata;
                end else begin
                    s_addr = pend_addr; s_w = pend_w; s_wdata = pend_wdata;
                end
                pend = 0;
            end
            cap = a_new_req && !ga;
            if (cap) begin
                if (pend) ovr = 1;
                else if (a_overrun_clr) ovr = 0;
                pend = 1; pend_addr = a_addr; pend_w = a_write; pend_wdata = a_wdata;
            end else if (a_overrun_clr) begin
                ovr = 0;
            end
            if (idle) begin
                if (gb || !b_req) cnt = 0;
                else if (ga && cnt < LIMIT) cnt++;
            end
            if (ga || gb) begin
                cur_valid = 1; cur_a = ga; cur_addr = s_addr; cur_w = s_w; cur_wdata = s_wdata;
                cur_grant = c; idle_at = c + 3;
                cur_rd = m_mem[s_addr];
                if (s_w) m_mem[s_addr] = s_wdata;
            end
            tick();
        end
        a_new_req = 1'b0; b_req = 1'b0; a_overrun_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_a_read();
        test_a_write();
        test_a_b_same();
        test_starve();
        test_overrun();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=no finish exp=finish");
        $fatal(1, "simulation time limit");
    end

endmodule
